// File: rtl/inst_queue_param.sv
// inst_queue_param
//   Circular instruction queue between decode and dispatch. Accepts up to
//   FETCH_W sparse decode lanes per cycle (compacted in lane order at the
//   tail) and presents DISP_W consecutive entries from the head.
//
// Configuration macro:
//   INSTBUF_PARTIAL_DISPATCH_EN - when defined, a dispatch group may be
//   narrower than DISP_W (any non-empty queue is presented). When undefined,
//   only full groups of DISP_W entries are presented.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset (clears pointers/count)
//   flush_i           synchronous flush, overrides enqueue and dequeue
//   stall_i           back-end stall, blocks dequeue
//   decodeReady_i     decode bundle present
//   decodedVector_i   per-lane valid of the decode bundle
//   decodedPacket_i   decode lanes, lane k at [k*PKT_W +: PKT_W]
//   stallFetch_o      queue cannot guarantee room for FETCH_W entries
//   instBufferReady_o dispatch group presented this cycle
//   dispValid_o       per-lane valid of the presented group
//   decodedPacket_o   lane j = entry at head+j
//   branchCount_o     number of valid output lanes with the branch flag set
//   instCount_o       current occupancy
module inst_queue_param #(
  parameter int DEPTH   = 32,
  parameter int FETCH_W = 8,
  parameter int DISP_W  = 4,
  parameter int PKT_W   = 128,
  parameter int BR_BIT  = 127
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         stall_i,
  input  logic                         decodeReady_i,
  input  logic [FETCH_W-1:0]           decodedVector_i,
  input  logic [FETCH_W*PKT_W-1:0]     decodedPacket_i,
  output logic                         stallFetch_o,
  output logic                         instBufferReady_o,
  output logic [DISP_W-1:0]            dispValid_o,
  output logic [DISP_W*PKT_W-1:0]      decodedPacket_o,
  output logic [$clog2(DISP_W+1)-1:0]  branchCount_o,
  output logic [$clog2(DEPTH):0]       instCount_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(DISP_W + 1);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic [CW-1:0]    nin, nout;
  logic [PW-1:0]    laneOff [FETCH_W];
  logic             enq, deq;
  logic [PKT_W-1:0] rdPkt [DISP_W];

  assign stallFetch_o = count > CW'(DEPTH - FETCH_W);
  assign enq          = decodeReady_i & ~stallFetch_o;
  assign deq          = instBufferReady_o & ~stall_i;
  assign instCount_o  = count;

  // Each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    nin = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      laneOff[k] = nin[PW-1:0];
      if (decodedVector_i[k]) nin = nin + CW'(1);
    end
  end

  always_comb begin
    dispValid_o = '0;
`ifdef INSTBUF_PARTIAL_DISPATCH_EN
    instBufferReady_o = (count != '0);
    for (int j = 0; j < DISP_W; j++) dispValid_o[j] = (CW'(j) < count);
`else
    instBufferReady_o = (count >= CW'(DISP_W));
    dispValid_o       = {DISP_W{instBufferReady_o}};
`endif
    nout = '0;
    for (int j = 0; j < DISP_W; j++) begin
      if (dispValid_o[j]) nout = nout + CW'(1);
    end
  end

  // Read port always shows storage as of before the edge; no write bypass.
  for (genvar j = 0; j < DISP_W; j++) begin : g_rd
    assign rdPkt[j] = mem[head + PW'(j)];
  end

  always_comb begin
    decodedPacket_o = '0;
    branchCount_o   = '0;
    for (int j = 0; j < DISP_W; j++) begin
      decodedPacket_o[j*PKT_W +: PKT_W] = rdPkt[j];
      if (dispValid_o[j] && rdPkt[j][BR_BIT]) branchCount_o = branchCount_o + BCW'(1);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq && !flush_i) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (decodedVector_i[k]) mem[tail + laneOff[k]] <= decodedPacket_i[k*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + nin[PW-1:0];
      if (deq) head <= head + nout[PW-1:0];
      count <= count + (enq ? nin : '0) - (deq ? nout : '0);
    end
  end

endmodule

// File: tb/tb_inst_queue_param.sv
module tb_inst_queue_param;
  localparam int DEPTH = 32, FETCH_W = 8, DISP_W = 4, PKT_W = 128, BR_BIT = 127;

  logic                        clk, reset, flush_i, stall_i, decodeReady_i;
  logic [FETCH_W-1:0]          decodedVector_i;
  logic [FETCH_W*PKT_W-1:0]    decodedPacket_i;
  logic                        stallFetch_o, instBufferReady_o;
  logic [DISP_W-1:0]           dispValid_o;
  logic [DISP_W*PKT_W-1:0]     decodedPacket_o;
  logic [2:0]                  branchCount_o;
  logic [5:0]                  instCount_o;

  int vecs = 0;
  int errs = 0;

  inst_queue_param #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DISP_W(DISP_W),
                     .PKT_W(PKT_W), .BR_BIT(BR_BIT)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i),
    .decodeReady_i(decodeReady_i), .decodedVector_i(decodedVector_i),
    .decodedPacket_i(decodedPacket_i), .stallFetch_o(stallFetch_o),
    .instBufferReady_o(instBufferReady_o), .dispValid_o(dispValid_o),
    .decodedPacket_o(decodedPacket_o), .branchCount_o(branchCount_o),
    .instCount_o(instCount_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Packet tag in bits [7:0]; branch flag set for odd tags.
  function automatic logic [PKT_W-1:0] mkPkt(input int tag);
    logic [PKT_W-1:0] p;
    p = '0;
    p[7:0] = tag[7:0];
    p[BR_BIT] = tag[0];
    return p;
  endfunction

  function automatic logic [7:0] tagOf(input int j);
    return decodedPacket_o[j*PKT_W +: 8];
  endfunction

  // One clock with the given inputs, then back to idle (stalled, no decode).
  task automatic drive(input logic dr, input logic [7:0] vec, input int base,
                       input logic st, input logic fl);
    decodeReady_i = dr;
    decodedVector_i = vec;
    for (int k = 0; k < FETCH_W; k++) decodedPacket_i[k*PKT_W +: PKT_W] = mkPkt(base + k);
    stall_i = st;
    flush_i = fl;
    @(posedge clk); #1;
    decodeReady_i = 0;
    decodedVector_i = '0;
    stall_i = 1;
    flush_i = 0;
  endtask

  task automatic test_reset;
    reset = 1; flush_i = 0; stall_i = 1; decodeReady_i = 0;
    decodedVector_i = '0; decodedPacket_i = '0;
    #2 reset = 0;
    #1;
    vecs++; if (instCount_o !== 6'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", instCount_o); end
    vecs++; if (stallFetch_o !== 1'b0) begin errs++; $display("FAIL rst_stallFetch: got %b want 0", stallFetch_o); end
    vecs++; if (instBufferReady_o !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b want 0", instBufferReady_o); end
    vecs++; if (dispValid_o !== 4'h0) begin errs++; $display("FAIL rst_dispValid: got %h want 0", dispValid_o); end
    vecs++; if (branchCount_o !== 3'd0) begin errs++; $display("FAIL rst_branchCount: got %0d want 0", branchCount_o); end
    #4 reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_bundle;
    drive(1, 8'hFF, 0, 1, 0);
    vecs++; if (instCount_o !== 6'd8) begin errs++; $display("FAIL full_count: got %0d want 8", instCount_o); end
    vecs++; if (instBufferReady_o !== 1'b1) begin errs++; $display("FAIL full_ready: got %b want 1", instBufferReady_o); end
    vecs++; if (dispValid_o !== 4'hF) begin errs++; $display("FAIL full_dispValid: got %h want f", dispValid_o); end
    vecs++; if ({tagOf(0), tagOf(1), tagOf(2), tagOf(3)} !== {8'd0, 8'd1, 8'd2, 8'd3})
      begin errs++; $display("FAIL full_tags: got %0d %0d %0d %0d want 0 1 2 3", tagOf(0), tagOf(1), tagOf(2), tagOf(3)); end
    vecs++; if (branchCount_o !== 3'd2) begin errs++; $display("FAIL full_branchCount: got %0d want 2", branchCount_o); end
    // Tail must be 8: the next entry lands behind the first eight.
    drive(1, 8'h01, 100, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    vecs++; if (instCount_o !== 6'd1) begin errs++; $display("FAIL full_drain_count: got %0d want 1", instCount_o); end
    vecs++; if (tagOf(0) !== 8'd100) begin errs++; $display("FAIL full_tail8: got %0d want 100", tagOf(0)); end
  endtask

  task automatic test_sparse;
    drive(0, 8'h00, 0, 1, 1);
    drive(1, 8'b1010_0101, 0, 1, 0);
    vecs++; if (instCount_o !== 6'd4) begin errs++; $display("FAIL sparse_count: got %0d want 4", instCount_o); end
    vecs++; if ({tagOf(0), tagOf(1), tagOf(2), tagOf(3)} !== {8'd0, 8'd2, 8'd5, 8'd7})
      begin errs++; $display("FAIL sparse_tags: got %0d %0d %0d %0d want 0 2 5 7", tagOf(0), tagOf(1), tagOf(2), tagOf(3)); end
    vecs++; if (branchCount_o !== 3'd2) begin errs++; $display("FAIL sparse_branchCount: got %0d want 2", branchCount_o); end
  endtask

  task automatic test_fill;
    drive(0, 8'h00, 0, 1, 1);
    drive(1, 8'hFF, 0, 1, 0);
    drive(1, 8'hFF, 8, 1, 0);
    drive(1, 8'hFF, 16, 1, 0);
    vecs++; if (stallFetch_o !== 1'b0) begin errs++; $display("FAIL fill24_stallFetch: got %b want 0", stallFetch_o); end
    drive(1, 8'h01, 24, 1, 0);
    vecs++; if (stallFetch_o !== 1'b1) begin errs++; $display("FAIL fill25_stallFetch: got %b want 1", stallFetch_o); end
    drive(1, 8'hFF, 200, 1, 0);
    vecs++; if (instCount_o !== 6'd25) begin errs++; $display("FAIL fill_drop_count: got %0d want 25", instCount_o); end
    drive(0, 8'h00, 0, 0, 0);
    vecs++; if (instCount_o !== 6'd21) begin errs++; $display("FAIL fill_deq_count: got %0d want 21", instCount_o); end
    vecs++; if (stallFetch_o !== 1'b0) begin errs++; $display("FAIL fill_deq_stallFetch: got %b want 0", stallFetch_o); end
    vecs++; if (tagOf(0) !== 8'd4) begin errs++; $display("FAIL fill_head_tag: got %0d want 4", tagOf(0)); end
  endtask

  task automatic test_wrap;
    drive(0, 8'h00, 0, 1, 1);
    drive(1, 8'hFF, 0, 1, 0);
    drive(1, 8'hFF, 8, 1, 0);
    drive(1, 8'hFF, 16, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(1, 8'hFF, 24, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(1, 8'hFF, 32, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    drive(1, 8'hFF, 40, 1, 0);
    drive(1, 8'h0F, 48, 1, 0);
    // head = 28, count = 24
    vecs++; if (instCount_o !== 6'd24) begin errs++; $display("FAIL wrap_pre_count: got %0d want 24", instCount_o); end
    vecs++; if ({tagOf(0), tagOf(1), tagOf(2), tagOf(3)} !== {8'd28, 8'd29, 8'd30, 8'd31})
      begin errs++; $display("FAIL wrap_pre_tags: got %0d %0d %0d %0d want 28 29 30 31", tagOf(0), tagOf(1), tagOf(2), tagOf(3)); end
    drive(1, 8'hFF, 52, 0, 0);
    vecs++; if (instCount_o !== 6'd28) begin errs++; $display("FAIL wrap_count: got %0d want 28", instCount_o); end
    vecs++; if ({tagOf(0), tagOf(3)} !== {8'd32, 8'd35})
      begin errs++; $display("FAIL wrap_head0: got %0d %0d want 32 35", tagOf(0), tagOf(3)); end
    vecs++; if (stallFetch_o !== 1'b1) begin errs++; $display("FAIL wrap_stallFetch: got %b want 1", stallFetch_o); end
  endtask

  task automatic test_count3;
    drive(0, 8'h00, 0, 1, 1);
    drive(1, 8'h07, 0, 1, 0);
    // slot 3 still holds stale tag 35 (branch flag set) from the wrap test
`ifdef INSTBUF_PARTIAL_DISPATCH_EN
    vecs++; if (instBufferReady_o !== 1'b1) begin errs++; $display("FAIL c3_ready: got %b want 1", instBufferReady_o); end
    vecs++; if (dispValid_o !== 4'b0111) begin errs++; $display("FAIL c3_dispValid: got %b want 0111", dispValid_o); end
    vecs++; if (branchCount_o !== 3'd1) begin errs++; $display("FAIL c3_branchCount: got %0d want 1", branchCount_o); end
    drive(0, 8'h00, 0, 0, 0);
    vecs++; if (instCount_o !== 6'd0) begin errs++; $display("FAIL c3_deq_count: got %0d want 0", instCount_o); end
`else
    vecs++; if (instBufferReady_o !== 1'b0) begin errs++; $display("FAIL c3_ready: got %b want 0", instBufferReady_o); end
    vecs++; if (dispValid_o !== 4'b0000) begin errs++; $display("FAIL c3_dispValid: got %b want 0000", dispValid_o); end
    vecs++; if (branchCount_o !== 3'd0) begin errs++; $display("FAIL c3_branchCount: got %0d want 0", branchCount_o); end
    drive(0, 8'h00, 0, 0, 0);
    vecs++; if (instCount_o !== 6'd3) begin errs++; $display("FAIL c3_deq_count: got %0d want 3", instCount_o); end
`endif
  endtask

  task automatic test_flush;
    drive(0, 8'h00, 0, 1, 1);
    drive(1, 8'hFF, 0, 1, 0);
    drive(1, 8'h0F, 8, 1, 0);
    vecs++; if (instCount_o !== 6'd12) begin errs++; $display("FAIL flush_pre_count: got %0d want 12", instCount_o); end
    drive(1, 8'hFF, 100, 0, 1);
    vecs++; if (instCount_o !== 6'd0) begin errs++; $display("FAIL flush_count: got %0d want 0", instCount_o); end
    vecs++; if (instBufferReady_o !== 1'b0) begin errs++; $display("FAIL flush_ready: got %b want 0", instBufferReady_o); end
    drive(1, 8'hFF, 40, 1, 0);
    vecs++; if ({tagOf(0), tagOf(1)} !== {8'd40, 8'd41})
      begin errs++; $display("FAIL flush_ptrs0: got %0d %0d want 40 41", tagOf(0), tagOf(1)); end
    // async reset pulse between edges
    #2 reset = 0;
    #1;
    vecs++; if (instCount_o !== 6'd0) begin errs++; $display("FAIL areset_count: got %0d want 0", instCount_o); end
    vecs++; if (instBufferReady_o !== 1'b0) begin errs++; $display("FAIL areset_ready: got %b want 0", instBufferReady_o); end
    vecs++; if (dispValid_o !== 4'h0) begin errs++; $display("FAIL areset_dispValid: got %h want 0", dispValid_o); end
    #1 reset = 1;
    @(posedge clk); #1;
    vecs++; if (instCount_o !== 6'd0) begin errs++; $display("FAIL areset_hold: got %0d want 0", instCount_o); end
  endtask

  initial begin
    test_reset;
    test_full_bundle;
    test_sparse;
    test_fill;
    test_wrap;
    test_count3;
    test_flush;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
